id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/cpu_pkg.sv | 41 ++++
 rtl/load_use_fsm.sv | 92 +++++++++
 rtl/id_ex_stage.sv | 86 ++++++++
 tb/tb_id_ex_stage.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants and types for the pipeline slice.
//   DATA_W / REG_AW : datapath and register-address widths
//   NOP_INST        : encoding placed in ID/EX for a bubble
//   *_MSB / *_LSB   : instruction field positions (op, rd, rs, rt)
//   lu_state_e      : load-use stall controller states
//   f_rd/f_rs/f_rt  : instruction field extractors
package cpu_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned REG_AW = 4;

  localparam logic [DATA_W-1:0] NOP_INST = 16'h0000;

  localparam int unsigned OP_MSB = 15;
  localparam int unsigned OP_LSB = 12;
  localparam int unsigned RD_MSB = 11;
  localparam int unsigned RD_LSB = 8;
  localparam int unsigned RS_MSB = 7;
  localparam int unsigned RS_LSB = 4;
  localparam int unsigned RT_MSB = 3;
  localparam int unsigned RT_LSB = 0;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL1 = 2'd1,
    ST_STALL2 = 2'd2
  } lu_state_e;

  function automatic logic [REG_AW-1:0] f_rd(input logic [DATA_W-1:0] inst);
    return inst[RD_MSB:RD_LSB];
  endfunction

  function automatic logic [REG_AW-1:0] f_rs(input logic [DATA_W-1:0] inst);
    return inst[RS_MSB:RS_LSB];
  endfunction

  function automatic logic [REG_AW-1:0] f_rt(input logic [DATA_W-1:0] inst);
    return inst[RT_MSB:RT_LSB];
  endfunction

endpackage

// File: rtl/load_use_fsm.sv
// load_use_fsm: load-use hazard detection and the two-bubble stall controller.
//   i_clk, i_rst_n      : clock, synchronous active-low reset
//   i_flush             : kill of the ID-stage instruction (highest priority)
//   i_rd/i_rs/i_rt_ifid : register fields of the instruction in ID
//   i_dmem_wen_id       : active-low store flag of the instruction in ID
//   i_rf_wen_idex, i_mem2reg_idex, i_rf_waddr_idex : instruction in EX
//   o_stall             : hold PC and IF/ID
//   o_bubble            : load a bubble into ID/EX on the next edge
module load_use_fsm
  import cpu_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic [REG_AW-1:0] i_rd_ifid,
  input  logic [REG_AW-1:0] i_rs_ifid,
  input  logic [REG_AW-1:0] i_rt_ifid,
  input  logic              i_dmem_wen_id,
  input  logic              i_rf_wen_idex,
  input  logic              i_mem2reg_idex,
  input  logic [REG_AW-1:0] i_rf_waddr_idex,
  output logic              o_stall,
  output logic              o_bubble
);

  lu_state_e r_state;
  lu_state_e w_next_state;
  logic      w_match;
  logic      w_hazard;
  logic      w_stall;
  logic      w_bubble;

  // rd is only a source operand for stores (dmem_wen active-low).
  always_comb begin
    w_match = (i_rf_waddr_idex == i_rs_ifid) ||
              (i_rf_waddr_idex == i_rt_ifid) ||
              (!i_dmem_wen_id && (i_rf_waddr_idex == i_rd_ifid));
  end

  // Detection only in RUN: during the stall states ID/EX holds bubbles.
  always_comb begin
    w_hazard = (r_state == ST_RUN) && i_rf_wen_idex && i_mem2reg_idex &&
               (i_rf_waddr_idex != '0) && w_match;
  end

  // Bubbles are issued on the edges leaving RUN (hazard) and STALL1; the
  // edge leaving STALL2 latches the dependent instruction, so a hazard
  // costs exactly two bubbles.
  always_comb begin
    w_next_state = r_state;
    w_stall      = 1'b0;
    w_bubble     = 1'b0;
    if (i_flush) begin
      w_next_state = ST_RUN;
      w_bubble     = 1'b1;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_hazard) begin
            w_next_state = ST_STALL1;
            w_stall      = 1'b1;
            w_bubble     = 1'b1;
          end
        end
        ST_STALL1: begin
          w_next_state = ST_STALL2;
          w_stall      = 1'b1;
          w_bubble     = 1'b1;
        end
        ST_STALL2: begin
          w_next_state = ST_RUN;
        end
        default: begin
          w_next_state = ST_RUN;
          w_bubble     = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  assign o_stall  = w_stall;
  assign o_bubble = w_bubble;

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall insertion.
//   clk, rst_n         : clock, synchronous active-low reset
//   inst_ifid          : instruction in ID ([15:12] op, [11:8] rd, [7:4] rs, [3:0] rt)
//   rdata1_id/2_id     : register-file data for rs/rt
//   rf_wen_id, mem2reg_id : active-high decoder controls
//   dmem_wen_id        : active-low data-memory write enable
//   flush              : branch-taken kill of the ID instruction
//   *_idex             : registered instruction, operands and controls
//   rf_waddr_idex      : destination register of the EX instruction
//   stall              : hold PC and IF/ID
module id_ex_stage
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] inst_ifid,
  input  logic [DATA_W-1:0] rdata1_id,
  input  logic [DATA_W-1:0] rdata2_id,
  input  logic              rf_wen_id,
  input  logic              mem2reg_id,
  input  logic              dmem_wen_id,
  input  logic              flush,
  output logic [DATA_W-1:0] inst_idex,
  output logic [DATA_W-1:0] rdata1_idex,
  output logic [DATA_W-1:0] rdata2_idex,
  output logic              rf_wen_idex,
  output logic              mem2reg_idex,
  output logic              dmem_wen_idex,
  output logic [REG_AW-1:0] rf_waddr_idex,
  output logic              stall
);

  logic [DATA_W-1:0] r_inst;
  logic [DATA_W-1:0] r_rdata1;
  logic [DATA_W-1:0] r_rdata2;
  logic              r_rf_wen;
  logic              r_mem2reg;
  logic              r_dmem_wen;
  logic              w_bubble;
  logic              w_stall;

  load_use_fsm u_load_use_fsm (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_flush         (flush),
    .i_rd_ifid       (f_rd(inst_ifid)),
    .i_rs_ifid       (f_rs(inst_ifid)),
    .i_rt_ifid       (f_rt(inst_ifid)),
    .i_dmem_wen_id   (dmem_wen_id),
    .i_rf_wen_idex   (r_rf_wen),
    .i_mem2reg_idex  (r_mem2reg),
    .i_rf_waddr_idex (f_rd(r_inst)),
    .o_stall         (w_stall),
    .o_bubble        (w_bubble)
  );

  // A bubble is an instruction with no side effects: no register write,
  // no load, store disabled (active-low enable held high).
  always_ff @(posedge clk) begin
    if (!rst_n || w_bubble) begin
      r_inst     <= NOP_INST;
      r_rdata1   <= '0;
      r_rdata2   <= '0;
      r_rf_wen   <= 1'b0;
      r_mem2reg  <= 1'b0;
      r_dmem_wen <= 1'b1;
    end else begin
      r_inst     <= inst_ifid;
      r_rdata1   <= rdata1_id;
      r_rdata2   <= rdata2_id;
      r_rf_wen   <= rf_wen_id;
      r_mem2reg  <= mem2reg_id;
      r_dmem_wen <= dmem_wen_id;
    end
  end

  assign inst_idex     = r_inst;
  assign rdata1_idex   = r_rdata1;
  assign rdata2_idex   = r_rdata2;
  assign rf_wen_idex   = r_rf_wen;
  assign mem2reg_idex  = r_mem2reg;
  assign dmem_wen_idex = r_dmem_wen;
  assign rf_waddr_idex = f_rd(r_inst);
  assign stall         = w_stall;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] inst_ifid;
  logic [15:0] rdata1_id, rdata2_id;
  logic        rf_wen_id, mem2reg_id, dmem_wen_id, flush;
  logic [15:0] inst_idex, rdata1_idex, rdata2_idex;
  logic        rf_wen_idex, mem2reg_idex, dmem_wen_idex;
  logic [3:0]  rf_waddr_idex;
  logic        stall;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .inst_ifid     (inst_ifid),
    .rdata1_id     (rdata1_id),
    .rdata2_id     (rdata2_id),
    .rf_wen_id     (rf_wen_id),
    .mem2reg_id    (mem2reg_id),
    .dmem_wen_id   (dmem_wen_id),
    .flush         (flush),
    .inst_idex     (inst_idex),
    .rdata1_idex   (rdata1_idex),
    .rdata2_idex   (rdata2_idex),
    .rf_wen_idex   (rf_wen_idex),
    .mem2reg_idex  (mem2reg_idex),
    .dmem_wen_idex (dmem_wen_idex),
    .rf_waddr_idex (rf_waddr_idex),
    .stall         (stall)
  );

  typedef struct {
    int          step;
    logic        chk_stall;
    logic        stall;
    logic [15:0] inst;
    logic [15:0] d1;
    logic [15:0] d2;
    logic        rfw;
    logic        m2r;
    logic        dwen;
  } exp_t;

  exp_t exp_q[$];

  localparam logic [3:0] OP_LD  = 4'h8;
  localparam logic [3:0] OP_ST  = 4'h9;
  localparam logic [3:0] OP_ADD = 4'h1;

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [3:0] rd,
                                     input logic [3:0] rs, input logic [3:0] rt);
    return {op, rd, rs, rt};
  endfunction

  task automatic chk(input int step, input string name, input logic [15:0] act,
                     input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL step %0d %s: got %h expected %h", step, name, act, req);
    end
  endtask

  // One cycle of stimulus: inputs applied after the falling edge. The record
  // holds the stall expected during this cycle and the ID/EX contents
  // expected after the following rising edge (ID inputs, or a bubble).
  int step_no = 0;
  task automatic step(input logic rst, input logic [15:0] inst, input logic rfw,
                      input logic m2r, input logic dwen, input logic fl,
                      input logic chk_st, input logic exp_stall, input logic exp_latch);
    exp_t e;
    logic [15:0] d1, d2;
    d1 = {4'hA, inst[11:0]};
    d2 = {4'hB, inst[11:0]};
    rst_n       = rst;
    inst_ifid   = inst;
    rdata1_id   = d1;
    rdata2_id   = d2;
    rf_wen_id   = rfw;
    mem2reg_id  = m2r;
    dmem_wen_id = dwen;
    flush       = fl;
    e.step      = step_no;
    e.chk_stall = chk_st;
    e.stall     = exp_stall;
    if (exp_latch) begin
      e.inst = inst; e.d1 = d1; e.d2 = d2; e.rfw = rfw; e.m2r = m2r; e.dwen = dwen;
    end else begin
      e.inst = 16'h0000; e.d1 = 16'h0000; e.d2 = 16'h0000;
      e.rfw = 1'b0; e.m2r = 1'b0; e.dwen = 1'b1;
    end
    exp_q.push_back(e);
    step_no++;
    @(negedge clk);
  endtask

  // Monitor: samples stall mid-low-phase, registered outputs just after the edge.
  initial begin : monitor
    logic s_stall;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      s_stall = stall;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.chk_stall) chk(e.step, "stall", {15'd0, s_stall}, {15'd0, e.stall});
        chk(e.step, "inst_idex", inst_idex, e.inst);
        chk(e.step, "rdata1_idex", rdata1_idex, e.d1);
        chk(e.step, "rdata2_idex", rdata2_idex, e.d2);
        chk(e.step, "rf_waddr_idex", {12'd0, rf_waddr_idex}, {12'd0, e.inst[11:8]});
        chk(e.step, "ctrl{rfw,m2r,dwen}", {13'd0, rf_wen_idex, mem2reg_idex, dmem_wen_idex},
            {13'd0, e.rfw, e.m2r, e.dwen});
      end
    end
  end

  initial begin : driver
    rst_n = 1'b0; inst_ifid = '0; rdata1_id = '0; rdata2_id = '0;
    rf_wen_id = 1'b0; mem2reg_id = 1'b0; dmem_wen_id = 1'b1; flush = 1'b0;
    @(negedge clk);
    //   rst   inst                          rfw  m2r  dwen fl   chk  stall latch
    // reset with junk on the inputs
    step(1'b0, mk(OP_LD, 4'd3, 4'd3, 4'd3), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, mk(OP_LD, 4'd3, 4'd3, 4'd3), 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    // load r3, dependent add on rs=r3: stall 1,1,0 then add issues
    step(1'b1, mk(OP_LD, 4'd3, 4'd1, 4'd0), 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, mk(OP_ADD, 4'd6, 4'd3, 4'd2), 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, mk(OP_ADD, 4'd6, 4'd3, 4'd2), 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, mk(OP_ADD, 4'd6, 4'd3, 4'd2), 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    // ALU r4 then use of r4: no stall
    step(1'b1, mk(OP_ADD, 4'd4, 4'd6, 4'd6), 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, mk(OP_ADD, 4'd7, 4'd4, 4'd4), 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    // load r0 then use of r0: no stall
    step(1'b1, mk(OP_LD, 4'd0, 4'd1, 4'd2), 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, mk(OP_ADD, 4'd5, 4'd0, 4'd0), 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    // load r5 then store with rd=r5: two bubbles, store enters with dwen=0
    step(1'b1, mk(OP_LD, 4'd5, 4'd2, 4'd3), 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, mk(OP_ST, 4'd5, 4'd1, 4'd2), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, mk(OP_ST, 4'd5, 4'd1, 4'd2), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, mk(OP_ST, 4'd5, 4'd1, 4'd2), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    // load r9 then non-store with rd=r9: rd is not a source, no stall
    step(1'b1, mk(OP_LD, 4'd9, 4'd1, 4'd2), 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, mk(OP_ADD, 4'd9, 4'd1, 4'd2), 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    // back-to-back dependent loads, then a use of the second load on rt
    step(1'b1, mk(OP_LD, 4'd10, 4'd1, 4'd1), 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, mk(OP_LD, 4'd11, 4'd10, 4'd0), 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, mk(OP_LD, 4'd11, 4'd10, 4'd0), 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, mk(OP_LD, 4'd11, 4'd10, 4'd0), 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, mk(OP_ADD, 4'd1, 4'd2, 4'd11), 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    // flush in STALL1: stall drops, bubble, back to RUN
    step(1'b1, mk(OP_ADD, 4'd1, 4'd2, 4'd11), 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, mk(OP_ADD, 4'd2, 4'd3, 4'd4), 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    // flush beats a hazard detected in RUN
    step(1'b1, mk(OP_LD, 4'd12, 4'd1, 4'd1), 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, mk(OP_ADD, 4'd3, 4'd12, 4'd1), 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, mk(OP_ADD, 4'd3, 4'd12, 4'd1), 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    // reset during STALL2 discards the stall
    step(1'b1, mk(OP_LD, 4'd13, 4'd1, 4'd1), 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, mk(OP_ADD, 4'd4, 4'd13, 4'd2), 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, mk(OP_ADD, 4'd4, 4'd13, 4'd2), 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, mk(OP_ADD, 4'd4, 4'd13, 4'd2), 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, mk(OP_ADD, 4'd4, 4'd13, 4'd2), 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expected records left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
